// File: rtl/rt_recovery_ctrl.sv
// rt_recovery_ctrl: sequences squash/halt recovery after retire and keeps the retired-instruction count.
// Optional perf counters (squash_count, block_cycles) are built only when RT_RECOVERY_PERF_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module rt_recovery_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [2:0]         i_rt_valid,
  input  logic               i_squash_flag,
  input  logic [`XLEN-1:0]   i_squash_pc,
  input  logic               i_halt,
  input  logic               i_sq_empty,
  output logic               o_flush_all,
  output logic               o_fetch_redirect,
  output logic [`XLEN-1:0]   o_fetch_redirect_pc,
  output logic               o_retire_block,
  output logic               o_halted,
  output logic [63:0]        o_retired_count,
  output logic [31:0]        o_squash_count,
  output logic [31:0]        o_block_cycles
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_HALT_DRAIN = 2'd2,
    ST_HALTED     = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  state_t             r_state;
  logic [3:0]         r_flush_cnt;
  logic               r_flush_all;
  logic               r_fetch_redirect;
  logic [`XLEN-1:0]   r_redirect_pc;
  logic               r_retire_block;
  logic               r_halted;
  logic [63:0]        r_retired_count;
  logic [63:0]        w_retire_inc;

  assign w_retire_inc = {62'd0, popcount3(i_rt_valid)};

  // Recovery FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= ST_RUN;
      r_flush_cnt      <= 4'd0;
      r_flush_all      <= 1'b0;
      r_fetch_redirect <= 1'b0;
      r_redirect_pc    <= '0;
      r_retire_block   <= 1'b0;
      r_halted         <= 1'b0;
      r_retired_count  <= 64'd0;
    end else begin
      r_fetch_redirect <= 1'b0;
      case (r_state)
        ST_RUN: begin
          // Slots retiring in the triggering cycle still count.
          r_retired_count <= r_retired_count + w_retire_inc;
          if (i_halt) begin
            r_state        <= ST_HALT_DRAIN;
            r_retire_block <= 1'b1;
            r_flush_all    <= 1'b0;
          end else if (i_squash_flag) begin
            r_state          <= ST_FLUSH;
            r_redirect_pc    <= i_squash_pc;
            r_flush_cnt      <= FLUSH_LOAD;
            r_flush_all      <= 1'b1;
            r_fetch_redirect <= 1'b1;
            r_retire_block   <= 1'b1;
          end else begin
            r_retire_block <= 1'b0;
            r_flush_all    <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_state        <= ST_RUN;
            r_flush_all    <= 1'b0;
            r_retire_block <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        ST_HALT_DRAIN: begin
          if (i_sq_empty) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_HALT_DRAIN;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state        <= ST_RUN;
          r_flush_all    <= 1'b0;
          r_retire_block <= 1'b0;
          r_halted       <= 1'b0;
        end
      endcase
    end
  end

  assign o_flush_all         = r_flush_all;
  assign o_fetch_redirect    = r_fetch_redirect;
  assign o_fetch_redirect_pc = r_redirect_pc;
  assign o_retire_block      = r_retire_block;
  assign o_halted            = r_halted;
  assign o_retired_count     = r_retired_count;

`ifdef RT_RECOVERY_PERF_EN
  logic [31:0] r_squash_count;
  logic [31:0] r_block_cycles;
  logic        w_squash_accept;

  assign w_squash_accept = (r_state == ST_RUN) && !i_halt && i_squash_flag;

  // Performance counters: accepted squashes and cycles spent blocking retirement.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_squash_count <= 32'd0;
      r_block_cycles <= 32'd0;
    end else begin
      if (w_squash_accept) begin
        r_squash_count <= r_squash_count + 32'd1;
      end else begin
        r_squash_count <= r_squash_count;
      end
      if (r_retire_block) begin
        r_block_cycles <= r_block_cycles + 32'd1;
      end else begin
        r_block_cycles <= r_block_cycles;
      end
    end
  end

  assign o_squash_count = r_squash_count;
  assign o_block_cycles = r_block_cycles;
`else
  assign o_squash_count = 32'd0;
  assign o_block_cycles = 32'd0;
`endif

endmodule

// File: doc/rt_recovery_ctrl.md
# rt_recovery_ctrl

Registered controller that sequences the machine after the retire stage reports a squash or a halt. It latches the redirect PC, asserts a multi-cycle pipeline flush and a fetch redirect, and blocks further retirement while recovery is in progress. On halt it waits for the store queue to drain before declaring the processor halted. It sits between the retire stage and the fetch, ROB, RS and map-table control inputs, and keeps the architectural retired-instruction count.

## Interface
Parameters:
- FLUSH_CYCLES, default 2: number of cycles flush_all is held high per squash; legal range 1..15.

Ports:
- clock  in  1: system clock; all state updates on the rising edge.
- reset  in  1: synchronous, active-high; forces IDLE-equivalent RUN state and clears all registers.
- rt_valid  in  3: per-slot retire valid from the retire stage; already gated past a halting slot.
- squash_flag  in  1: some valid retiring slot took a branch this cycle.
- squash_pc  in  `XLEN: redirect target accompanying squash_flag.
- halt  in  1: some valid retiring slot is a halt.
- sq_empty  in  1: store queue holds no committed-but-unwritten stores.
- flush_all  out  1: clear ROB, RS, map table and in-flight FU state.
- fetch_redirect  out  1: one-cycle pulse; fetch loads fetch_redirect_pc.
- fetch_redirect_pc  out  `XLEN: latched squash_pc.
- retire_block  out  1: ROB must present no valid retire slots while high.
- halted  out  1: sticky; processor has finished.
- retired_count  out  64: total instructions retired since reset.
- squash_count  out  32: number of squashes accepted (see Configuration).
- block_cycles  out  32: cycles with retire_block high (see Configuration).

## Operation
- States: RUN, FLUSH, HALT_DRAIN, HALTED. State encoding is 2 bits.
- RUN: retire_block=0.
  - If halt=1, go to HALT_DRAIN. Halt wins over squash_flag in the same cycle.
  - Else, if squash_flag=1, go to FLUSH, latch squash_pc, and load flush_cnt=FLUSH_CYCLES-1.
- FLUSH: flush_all=1 and retire_block=1. fetch_redirect=1 only in the first FLUSH cycle.
  - flush_cnt decrements each cycle; when flush_cnt=0, return to RUN.
  - squash_flag and halt are ignored in this state.
- HALT_DRAIN: retire_block=1, flush_all=0. Go to HALTED on the first cycle with sq_empty=1.
- HALTED: halted=1 and retire_block=1. No exit except reset.
- retired_count: adds popcount(rt_valid) (0..3) in any cycle where the state is RUN.
  - This includes the cycle that triggers FLUSH or HALT_DRAIN, since those slots do retire.
  - rt_valid is not counted in any other state.
  - Unsigned 64-bit addition that wraps.
- All outputs come directly from registers; there is no combinational path from input to output.

## Timing
- Reset values: state=RUN, all outputs 0, fetch_redirect_pc=0, all counters 0, flush_cnt=0.
- Squash seen at cycle t:
  - fetch_redirect and flush_all are high at t+1.
  - flush_all is held through t+FLUSH_CYCLES.
  - retire_block is high over the same window.
  - The state is RUN again at t+FLUSH_CYCLES+1, where a new squash can be accepted.
- Halt seen at cycle t: retire_block is high from t+1.
  - If sq_empty=1 at t+1, halted=1 at t+2.
  - Otherwise halted=1 one cycle after the first cycle with sq_empty=1.
- sq_empty is not sampled during RUN.
- FLUSH_CYCLES=1: flush_all and fetch_redirect are both high for exactly one cycle.
- Back-to-back squashes at t and t+1: the second is ignored, because rt_valid is already blocked.
- Reset asserted mid-FLUSH or mid-HALT_DRAIN: all state is cleared at the next edge, with no residual pulses.

## Configuration
- RT_RECOVERY_PERF_EN defined:
  - squash_count increments once per accepted RUN→FLUSH transition.
  - block_cycles increments every cycle retire_block=1.
  - Both are 32-bit, wrap, and are cleared by reset.
- RT_RECOVERY_PERF_EN undefined:
  - The squash_count and block_cycles ports still exist, tied to 0.
  - No counter registers are synthesized.
- retired_count is always present.

## Test plan
- Reset, then RUN with rt_valid=3'b111 for 4 cycles, then 3'b011 for 1 cycle -> retired_count=14; all other outputs 0.
- FLUSH_CYCLES=2: squash_flag=1, squash_pc=32'h0000_0100, rt_valid=3'b011 at t -> fetch_redirect high only at t+1 with pc 32'h100; flush_all and retire_block high at t+1 and t+2; RUN at t+3; retired_count +2.
- halt=1 and squash_flag=1 in the same cycle, sq_empty=0 for 3 cycles then 1 -> no flush_all and no fetch_redirect; retire_block stays high; halted rises one cycle after sq_empty=1 and stays high for 20 further cycles.
- squash_flag held high for 5 consecutive cycles with FLUSH_CYCLES=2 -> exactly two FLUSH windows (accepted at t and t+3); with RT_RECOVERY_PERF_EN, squash_count=2 and block_cycles=4.
- reset asserted at the second FLUSH cycle -> next cycle flush_all=0, retire_block=0, all counters 0, state RUN.
- Build without RT_RECOVERY_PERF_EN and repeat the previous squash scenario -> squash_count=0 and block_cycles=0 throughout, all other outputs identical.
